// File: rtl/wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: ALU result, load-return handshake,
// hazard query and the registered register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;

    logic [4:0]      chk_rs;
    logic            chk_pending;

    logic [4:0]      WriteRegister;
    logic [XLEN-1:0] WriteData;
    logic            WriteEnable;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output chk_rs,
        input  ld_ready, chk_pending,
        input  WriteRegister, WriteData, WriteEnable
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  chk_rs,
        output ld_ready, chk_pending,
        output WriteRegister, WriteData, WriteEnable
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the ALU result owns the register-file port outright;
// load returns queue in a small FIFO and drain on ALU-idle cycles. Queued
// loads overwritten by a later ALU write are marked dead so they cannot
// clobber the newer value, but they still drain in order.
module wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [4:0]      rd_q   [DEPTH];
    logic [4:0]      rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]   w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic [4:0]      wr_q, wr_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            we_q, we_d;

    logic ld_ready, accept, enq, pop, alu_kill;

    assign ld_ready = (count_q < DEPTH_C);
    assign accept   = bus.ld_valid && ld_ready;
    assign enq      = accept && (bus.ld_rd != 5'd0);
    assign pop      = !bus.alu_valid && (count_q != '0);
    assign alu_kill = bus.alu_valid && (bus.alu_rd != 5'd0);

    assign bus.ld_ready      = ld_ready;
    assign bus.WriteRegister = wr_q;
    assign bus.WriteData     = wd_q;
    assign bus.WriteEnable   = we_q;

    // Hazard query: live bits are only ever set on resident entries, because
    // a pop clears the head's live bit as it leaves.
    always_comb begin
        bus.chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == bus.chk_rs) && (bus.chk_rs != 5'd0))
                bus.chk_pending = 1'b1;
        end
    end

    // FIFO next state: kill, then pop-clear, then enqueue (the new load is
    // younger than a same-edge ALU write, so it lands live).
    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        live_d  = live_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (alu_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == bus.alu_rd)
                    live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[r_ptr_q] = 1'b0;
            r_ptr_d         = r_ptr_q + 1'b1;
        end
        if (enq) begin
            rd_d[w_ptr_q]   = bus.ld_rd;
            data_d[w_ptr_q] = bus.ld_data;
            live_d[w_ptr_q] = 1'b1;
            w_ptr_d         = w_ptr_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Write-port next state: ALU first, else drain head, else idle with hold.
    always_comb begin
        wr_d = wr_q;
        wd_d = wd_q;
        we_d = 1'b0;
        if (bus.alu_valid) begin
            wr_d = bus.alu_rd;
            wd_d = bus.alu_data;
            we_d = (bus.alu_rd != 5'd0);
        end else if (pop) begin
            wr_d = rd_q[r_ptr_q];
            wd_d = data_q[r_ptr_q];
            we_d = live_q[r_ptr_q];
        end
    end

    // State registers; reset empties the FIFO and silences the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            live_q  <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            wr_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            live_q  <= live_d;
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the register data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the load-return FIFO entries (power of two, 2..16).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port alu_valid  input  1  ALU result present this cycle; never stalled.
REQ-006 Port alu_rd  input  5  ALU destination register.
REQ-007 Port alu_data  input  XLEN  ALU result.
REQ-008 Port ld_valid  input  1  load return offered.
REQ-009 Port ld_ready  output  1  FIFO can accept a load return.
REQ-010 Port ld_rd  input  5  load destination register.
REQ-011 Port ld_data  input  XLEN  load return data.
REQ-012 Port chk_rs  input  5  hazard query register index.
REQ-013 Port chk_pending  output  1  chk_rs has an outstanding live load in the FIFO.
REQ-014 Port WriteRegister  output  5  register-file write index, registered.
REQ-015 Port WriteData  output  XLEN  register-file write data, registered.
REQ-016 Port WriteEnable  output  1  register-file write strobe, registered.

Function
REQ-017 Load accept SHALL occur at a rising edge when ld_valid=1 and ld_ready=1; ld_ready SHALL equal (count < DEPTH), with count from registers only (no same-cycle pop pass-through).
REQ-018 Accepted loads with ld_rd=0 SHALL be consumed (handshake completes) but not enqueued.
REQ-019 Each FIFO entry SHALL hold rd, data and a live bit; enqueued entries are live.
REQ-020 When alu_valid=1, the output registers SHALL load {alu_rd, alu_data, WriteEnable=(alu_rd!=0)} at the next edge: ALU latency 1 cycle, absolute priority.
REQ-021 When alu_valid=0 and count>0, the head entry SHALL be popped at the next edge; output registers load {rd, data, WriteEnable=live}.
REQ-022 When alu_valid=0 and count=0, WriteEnable SHALL be 0 after the next edge; WriteRegister/WriteData hold their prior values.
REQ-023 Minimum load latency: accepted at edge E, written (WriteEnable=1) in the cycle after edge E+1.
REQ-024 WAW kill: when alu_valid=1 and alu_rd!=0, every FIFO entry already resident with rd==alu_rd SHALL have live cleared at that edge.
REQ-025 A load accepted at the same edge as an ALU write to the same rd SHALL be treated as younger and enqueued live.
REQ-026 A dead entry SHALL still consume one pop cycle and SHALL produce WriteEnable=0.
REQ-027 Simultaneous accept and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 chk_pending SHALL be combinational: 1 iff chk_rs!=0 and any resident live entry has rd==chk_rs.
REQ-029 FIFO order SHALL be strict accept order; no entry is dropped except per REQ-018 and REQ-026.

Reset
REQ-030 While rst_n=0 (asynchronously): count=0, pointers=0, all live bits=0, WriteEnable=0, WriteRegister=0, WriteData=0.
REQ-031 After reset, ld_ready=1 and chk_pending=0; reset mid-stream SHALL discard all FIFO contents with no further writes.

Verification
REQ-032 ALU only: alu_valid=1, rd=5, data=0x11 -> next cycle WE=1, WR=5, WD=0x11; rd=0 -> WE=0.
REQ-033 Load idle path: ld rd=7 data=0xAB accepted at edge E, alu_valid=0 -> WE=1, WR=7, WD=0xAB after edge E+1; chk_pending(7)=1 between E and E+1 only.
REQ-034 Backpressure: alu_valid=1 constantly, offer 5 loads -> 4 accepted, ld_ready=0 on the 5th; drop alu_valid -> 4 writes in order on consecutive cycles, then ld_ready=1.
REQ-035 WAW kill: load rd=3 data=0x1 resident, then ALU rd=3 data=0x2 -> WE writes 0x2; later pop of the load yields WE=0; x3 final value 0x2.
REQ-036 Same-edge tie: ALU rd=9 data=0x5 and load rd=9 data=0x6 accepted same edge -> ALU write first, then load write 0x6.
REQ-037 Reset mid-operation: FIFO holding 3 entries, rst_n=0 asynchronously -> WE=0 immediately, count=0, ld_ready=1, no writes after release.
